// File: rtl/decode_ctrl_pkg.sv
// Purpose: shared types and constants for the decode->execute control pipe.
// Latency: n/a (package only).
// Backpressure: n/a. Holds the field layout, the side-effect mask and pack/unpack helpers.
package decode_ctrl_pkg;

  localparam int CTRL_WORD_W  = 14;

  // Field positions, LSB first.
  localparam int PC_LOAD_LSB  = 0;
  localparam int WRITE_LSB    = 1;
  localparam int ADR_MUX_LSB  = 2;
  localparam int WRITE_AD_LSB = 3;
  localparam int WRITE_AD_W   = 3;
  localparam int WREN_LSB     = 6;
  localparam int INPUT_LSB    = 7;
  localparam int ALU_LSB      = 8;
  localparam int ALU_W        = 4;
  localparam int BR_LSB       = 12;
  localparam int AR_LSB       = 13;

  // Bits that cause architectural side effects: PC_load, write, wren.
  localparam logic [CTRL_WORD_W-1:0] SE_MASK_DFLT = 14'h0043;

  // Declared MSB first so the packed layout matches the bit positions above.
  typedef struct packed {
    logic                  ar;
    logic                  br;
    logic [ALU_W-1:0]      alu;
    logic                  in_sel;
    logic                  wren;
    logic [WRITE_AD_W-1:0] write_ad;
    logic                  adr_mux;
    logic                  write;
    logic                  pc_load;
  } ctrl_word_t;

  // Occupancy of the 2-entry skid, derived from its valid bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  function automatic ctrl_word_t unpack_ctrl(input logic [CTRL_WORD_W-1:0] w);
    ctrl_word_t c;
    c.pc_load  = w[PC_LOAD_LSB];
    c.write    = w[WRITE_LSB];
    c.adr_mux  = w[ADR_MUX_LSB];
    c.write_ad = w[WRITE_AD_LSB +: WRITE_AD_W];
    c.wren     = w[WREN_LSB];
    c.in_sel   = w[INPUT_LSB];
    c.alu      = w[ALU_LSB +: ALU_W];
    c.br       = w[BR_LSB];
    c.ar       = w[AR_LSB];
    return c;
  endfunction

  function automatic logic [CTRL_WORD_W-1:0] pack_ctrl(input ctrl_word_t c);
    logic [CTRL_WORD_W-1:0] w;
    w                             = '0;
    w[PC_LOAD_LSB]                = c.pc_load;
    w[WRITE_LSB]                  = c.write;
    w[ADR_MUX_LSB]                = c.adr_mux;
    w[WRITE_AD_LSB +: WRITE_AD_W] = c.write_ad;
    w[WREN_LSB]                   = c.wren;
    w[INPUT_LSB]                  = c.in_sel;
    w[ALU_LSB +: ALU_W]           = c.alu;
    w[BR_LSB]                     = c.br;
    w[AR_LSB]                     = c.ar;
    return w;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_skid_buffer.sv
// Purpose: generic 2-entry valid/ready skid buffer with synchronous flush.
// Latency: 1 cycle accept->out_valid; 1 word/cycle sustained.
// Backpressure: in_ready = !skid valid, registered, no comb path from out_ready.
// Ports: CLK/RST_N, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module skid_buffer
  import decode_ctrl_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_main_vld;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_main_dat;
  logic [WIDTH-1:0] r_skid_dat;

  skid_state_t w_state;
  logic        w_acc;
  logic        w_dlv;
  logic        w_main_vld_nxt;
  logic        w_skid_vld_nxt;
  logic        w_main_ld_in;
  logic        w_main_ld_skid;
  logic        w_skid_ld;

  assign w_acc = in_valid && !r_skid_vld;
  assign w_dlv = r_main_vld && out_ready;

  always_comb begin
    w_state = ST_EMPTY;
    if (r_skid_vld)      w_state = ST_FULL;
    else if (r_main_vld) w_state = ST_ONE;
  end

  always_comb begin
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      // Flush wins over any accept/deliver; data registers are left as-is.
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else begin
      unique case (w_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_main_vld_nxt = 1'b1;
            w_main_ld_in   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_dlv) begin
            w_main_ld_in   = 1'b1;
          end else if (w_acc) begin
            w_skid_vld_nxt = 1'b1;
            w_skid_ld      = 1'b1;
          end else if (w_dlv) begin
            w_main_vld_nxt = 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a deliver can happen.
          if (w_dlv) begin
            w_main_ld_skid = 1'b1;
            w_skid_vld_nxt = 1'b0;
          end
        end
        default: begin
          w_main_vld_nxt = 1'b0;
          w_skid_vld_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main_dat <= '0;
      r_skid_dat <= '0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      if (w_main_ld_in)        r_main_dat <= in_data;
      else if (w_main_ld_skid) r_main_dat <= r_skid_dat;
      if (w_skid_ld)           r_skid_dat <= in_data;
    end
  end

  assign in_ready  = !r_skid_vld;
  assign out_valid = r_main_vld;
  assign out_data  = r_main_dat;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Purpose: decode->execute control word pipe: skid buffer, side-effect masking, stall counter.
// Latency: 1 cycle accept->out_valid; 1 word/cycle sustained.
// Backpressure: in_ready registered (low only when both entries held); flush empties the pipe.
// Ports: CLK/RST_N, flush, in_valid/in_ready/in_ctrl, out_valid/out_ready/out_ctrl, stall_cnt.
module decode_ctrl_pipe
  import decode_ctrl_pkg::*;
#(
  parameter int                CTRL_W  = CTRL_WORD_W,
  parameter logic [CTRL_W-1:0] SE_MASK = CTRL_W'(SE_MASK_DFLT),
  parameter int                CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_main_vld;
  logic [CTRL_W-1:0] w_main_dat;
  logic              w_stall;
  logic [CNT_W-1:0]  r_stall_cnt;

  skid_buffer #(
    .WIDTH (CTRL_W)
  ) u_skid (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_ctrl),
    .out_valid (w_main_vld),
    .out_ready (out_ready),
    .out_data  (w_main_dat)
  );

  // A bubble keeps its stale payload but can never fire a write, wren or PC load.
  assign out_valid = w_main_vld;
  assign out_ctrl  = w_main_dat & ~(SE_MASK & {CTRL_W{~w_main_vld}});

  assign w_stall = w_main_vld && !out_ready;

  // Saturating; deliberately untouched by flush so stalls across flushes add up.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;
  import decode_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [13:0] in_ctrl = '0;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [13:0] out_ctrl, out_ctrl4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  decode_ctrl_pipe u_dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  decode_ctrl_pipe #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
    .stall_cnt(stall_cnt4)
  );

  // Reference model: a FIFO of at most two words, the last word shown at the
  // output, and an unbounded count of stalled cycles.
  logic [13:0] m_q[$];
  logic [13:0] m_last = '0;
  int          m_stall = 0;

  function automatic logic [13:0] no_side_effects(input logic [13:0] w);
    ctrl_word_t c;
    c = unpack_ctrl(w);
    c.pc_load = 1'b0;
    c.write   = 1'b0;
    c.wren    = 1'b0;
    return pack_ctrl(c);
  endfunction

  function automatic logic [13:0] m_ctrl();
    return (m_q.size() > 0) ? m_q[0] : no_side_effects(m_last);
  endfunction

  function automatic logic [15:0] m_cnt16();
    return (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
  endfunction

  function automatic logic [3:0] m_cnt4();
    return (m_stall > 15) ? 4'hF : 4'(m_stall);
  endfunction

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic step(input logic iv, input logic [13:0] d, input logic orr, input logic fl);
    bit acc, dlv;
    in_valid  = iv;
    in_ctrl   = d;
    out_ready = orr;
    flush     = fl;
    acc = iv && (m_q.size() < 2);
    dlv = (m_q.size() > 0) && orr;
    if ((m_q.size() > 0) && !orr) m_stall++;
    @(posedge CLK);
    if (fl) m_q.delete();
    else begin
      if (dlv) void'(m_q.pop_front());
      if (acc) m_q.push_back(d);
    end
    if (m_q.size() > 0) m_last = m_q[0];
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_ctrl !== 14'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 0000", out_ctrl); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    RST_N = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 14'(k), 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (out_ctrl !== 14'(k)) begin errors++; $display("FAIL stream_ctrl[%0d]: got %h expected %h", k, out_ctrl, 14'(k)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, in_ready); end
    end
    step(1'b0, 14'($urandom), 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b expected 0", out_valid); end
    checks++; if (out_ctrl !== m_ctrl()) begin errors++; $display("FAIL stream_idle_ctrl: got %h expected %h", out_ctrl, m_ctrl()); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    logic [13:0] exp_seq[3];
    int          idx;
    int          stall_base;
    bit          sent3;
    exp_seq[0] = 14'h1111; exp_seq[1] = 14'h2222; exp_seq[2] = 14'h3333;
    stall_base = m_stall;
    step(1'b1, 14'h1111, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_first: got %b expected 1", in_ready); end
    step(1'b1, 14'h2222, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_second: got %b expected 0", in_ready); end
    step(1'b1, 14'h3333, 1'b0, 1'b0);
    step(1'b1, 14'h3333, 1'b0, 1'b0);
    checks++; if (out_ctrl !== 14'h1111) begin errors++; $display("FAIL bp_head_held: got %h expected 1111", out_ctrl); end
    checks++; if (stall_cnt !== 16'(stall_base + 3)) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_cnt, stall_base + 3); end
    idx = 0;
    sent3 = 1'b0;
    for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
      if (out_valid === 1'b1) begin
        checks++; if (out_ctrl !== exp_seq[idx]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", idx, out_ctrl, exp_seq[idx]); end
        idx++;
      end
      if (!sent3 && in_ready === 1'b1) begin
        sent3 = 1'b1;
        step(1'b1, 14'h3333, 1'b1, 1'b0);
      end else begin
        step(!sent3, 14'h3333, 1'b1, 1'b0);
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_drain_count: got %0d words expected 3", idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush_full();
    step(1'b1, 14'h0A5A, 1'b0, 1'b0);
    step(1'b1, 14'h15A5, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull_ready: got %b expected 0", in_ready); end
    step(1'b1, 14'h3FFF, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    checks++; if ({out_ctrl[6], out_ctrl[1], out_ctrl[0]} !== 3'b000) begin errors++; $display("FAIL flush_se_bits: got %b expected 000", {out_ctrl[6], out_ctrl[1], out_ctrl[0]}); end
    checks++; if (stall_cnt !== m_cnt16()) begin errors++; $display("FAIL flush_stall_kept: got %0d expected %0d", stall_cnt, m_cnt16()); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 14'($urandom), 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || out_ctrl === 14'h3FFF) begin errors++; $display("FAIL flush_no_leak[%0d]: got valid=%b ctrl=%h expected valid=0 ctrl!=3fff", i, out_valid, out_ctrl); end
    end
  endtask

  task automatic test_masking();
    step(1'b1, 14'h3FFF, 1'b1, 1'b0);
    checks++; if (out_ctrl !== 14'h3FFF) begin errors++; $display("FAIL mask_valid_word: got %h expected 3fff", out_ctrl); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 14'($urandom), 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || out_ctrl !== 14'h3FBC) begin errors++; $display("FAIL mask_idle[%0d]: got valid=%b ctrl=%h expected valid=0 ctrl=3fbc", i, out_valid, out_ctrl); end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 14'h0123, 1'b0, 1'b0);
    step(1'b1, 14'h0456, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    m_q.delete();
    m_last  = '0;
    m_stall = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
    checks++; if (out_ctrl !== 14'h0 || stall_cnt !== 16'h0) begin errors++; $display("FAIL areset_ctrl_cnt: got ctrl=%h cnt=%0d expected 0 and 0", out_ctrl, stall_cnt); end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step(1'b1, 14'h0155, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 14'h0155) begin errors++; $display("FAIL areset_first_word: got valid=%b ctrl=%h expected 1 0155", out_valid, out_ctrl); end
    step(1'b0, 14'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_stall_saturation();
    step(1'b1, 14'h2AAA, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 14'($urandom), 1'b0, 1'b0);
      checks++; if (stall_cnt4 !== m_cnt4() || stall_cnt !== m_cnt16()) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cnt4, stall_cnt, m_cnt4(), m_cnt16()); end
    end
    checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_final: got %0d expected 15", stall_cnt4); end
    step(1'b0, 14'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic       iv, orr, fl;
    logic [13:0] d;
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      d   = 14'($urandom);
      step(iv, d, orr, fl);
      checks++;
      if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) || out_ctrl !== m_ctrl()) begin
        errors++;
        $display("FAIL rand_main[%0d]: got v=%b r=%b c=%h expected v=%b r=%b c=%h", n, out_valid, in_ready, out_ctrl, m_q.size() > 0, m_q.size() < 2, m_ctrl());
      end
      checks++;
      if (stall_cnt !== m_cnt16() || stall_cnt4 !== m_cnt4() || out_ctrl4 !== m_ctrl() || out_valid4 !== (m_q.size() > 0) || in_ready4 !== (m_q.size() < 2)) begin
        errors++;
        $display("FAIL rand_aux[%0d]: got cnt=%0d cnt4=%0d c4=%h expected cnt=%0d cnt4=%0d c4=%h", n, stall_cnt, stall_cnt4, out_ctrl4, m_cnt16(), m_cnt4(), m_ctrl());
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_masking();
    test_async_reset();
    test_stall_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
